// File: rtl/poly_fir_ctrl_pkg.sv
// Shared definitions for the polyphase FIR controller: FSM encoding, phase count
// and default widths.
package poly_fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned N_PHASES    = 4;
  localparam int unsigned PHASE_W     = $clog2(N_PHASES);
  localparam int unsigned NB_DIV_DEF  = 8;
  localparam int unsigned NB_UNDR_DEF = 8;

endpackage

// File: rtl/poly_fir_ctrl_clk_en_div.sv
// Enable divider: counts while running and flags the edge on which the count
// reaches the latched ratio, where it wraps back to zero.
module poly_fir_ctrl_clk_en_div
  import poly_fir_ctrl_pkg::*;
#(
  parameter int unsigned NB_DIV = NB_DIV_DEF
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              run_i,
  input  logic              clr_i,
  input  logic [NB_DIV-1:0] div_i,
  output logic              wrap_o
);

  logic [NB_DIV-1:0] cnt_q, cnt_d;

  assign wrap_o = run_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (run_i)
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/poly_fir_ctrl.sv
// Feeds 1-bit symbols to a 4-phase polyphase FIR: one enable pulse per divider
// wrap, a new symbol only on phase 0, missed phase-0 slots counted as underruns.
module poly_fir_ctrl
  import poly_fir_ctrl_pkg::*;
#(
  parameter int unsigned NB_DIV  = NB_DIV_DEF,
  parameter int unsigned NB_UNDR = NB_UNDR_DEF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [NB_DIV-1:0]  i_div,
  input  logic               i_sym_valid,
  input  logic               i_sym_data,
  output logic               o_sym_ready,
  output logic               o_fir_en,
  output logic               o_fir_valid,
  output logic               o_fir_data,
  output logic [1:0]         o_phase,
  output logic               o_busy,
  output logic [NB_UNDR-1:0] o_underrun
);

  state_e               state_q, state_d;
  logic [NB_DIV-1:0]    div_q, div_d;
  logic                 stg_full_q, stg_full_d;
  logic                 stg_data_q, stg_data_d;
  logic                 act_q, act_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   ophase_q, ophase_d;
  logic                 fir_en_q, fir_en_d;
  logic                 fir_valid_q, fir_valid_d;
  logic [NB_UNDR-1:0]   undr_q, undr_d;
  logic                 wrap;
  logic                 start_go;

  function automatic logic [NB_UNDR-1:0] sat_inc(input logic [NB_UNDR-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  poly_fir_ctrl_clk_en_div #(.NB_DIV(NB_DIV)) u_div (
    .clk    (clk),
    .i_rst  (i_rst),
    .run_i  (state_q != ST_IDLE),
    .clr_i  (start_go),
    .div_i  (div_q),
    .wrap_o (wrap)
  );

  always_ff @(posedge clk) begin
    if (i_rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // DRAIN only ends on a symbol boundary, so the filter never sees a partial symbol.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start && !i_stop) state_d = ST_RUN;
      ST_RUN:   if (i_stop) state_d = ST_DRAIN;
      ST_DRAIN: if (phase_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_sym_ready = (state_q == ST_RUN) && !stg_full_q;
  end

  assign start_go = (state_q == ST_IDLE) && (state_d == ST_RUN);

  always_comb begin
    div_d       = (state_q == ST_IDLE) ? i_div : div_q;
    stg_full_d  = stg_full_q;
    stg_data_d  = stg_data_q;
    act_d       = act_q;
    phase_d     = phase_q;
    ophase_d    = ophase_q;
    fir_en_d    = 1'b0;
    fir_valid_d = 1'b0;
    undr_d      = start_go ? '0 : undr_q;

    if (i_sym_valid && o_sym_ready) begin
      stg_full_d = 1'b1;
      stg_data_d = i_sym_data;
    end

    if (wrap && (state_q == ST_RUN)) begin
      fir_en_d = 1'b1;
      ophase_d = phase_q;
      if (phase_q != '0) begin
        phase_d = phase_q + 1'b1;
      end else if (stg_full_q) begin
        act_d       = stg_data_q;
        stg_full_d  = 1'b0;
        fir_valid_d = 1'b1;
        phase_d     = phase_q + 1'b1;
      end else begin
        undr_d = sat_inc(undr_q);
      end
    end else if (wrap && (state_q == ST_DRAIN) && (phase_q != '0)) begin
      fir_en_d = 1'b1;
      ophase_d = phase_q;
      phase_d  = phase_q + 1'b1;
    end

    // A symbol still staged when draining finishes is never sent.
    if ((state_q == ST_DRAIN) && (phase_q == '0))
      stg_full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      div_q       <= '0;
      stg_full_q  <= 1'b0;
      stg_data_q  <= 1'b0;
      act_q       <= 1'b0;
      phase_q     <= '0;
      ophase_q    <= '0;
      fir_en_q    <= 1'b0;
      fir_valid_q <= 1'b0;
      undr_q      <= '0;
    end else begin
      div_q       <= div_d;
      stg_full_q  <= stg_full_d;
      stg_data_q  <= stg_data_d;
      act_q       <= act_d;
      phase_q     <= phase_d;
      ophase_q    <= ophase_d;
      fir_en_q    <= fir_en_d;
      fir_valid_q <= fir_valid_d;
      undr_q      <= undr_d;
    end
  end

  assign o_fir_en    = fir_en_q;
  assign o_fir_valid = fir_valid_q;
  assign o_fir_data  = act_q;
  assign o_phase     = ophase_q;
  assign o_underrun  = undr_q;

endmodule

// File: tb/tb_poly_fir_ctrl.sv
// Directed bench for poly_fir_ctrl: streaming, continuous enable, underrun,
// drain and mid-symbol reset, each with hand-derived expectations.
module tb_poly_fir_ctrl;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_stop, i_sym_valid, i_sym_data;
  logic [7:0] i_div;
  logic       o_sym_ready, o_fir_en, o_fir_valid, o_fir_data, o_busy;
  logic [1:0] o_phase;
  logic [7:0] o_underrun;

  int   n_vec = 0;
  int   n_err = 0;
  logic src_q [64];
  int   src_n = 0;
  int   src_idx = 0;
  int   hs_cnt = 0;
  int   u0, h0, pulses;

  always #5 clk = ~clk;

  poly_fir_ctrl dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_div       (i_div),
    .i_sym_valid (i_sym_valid),
    .i_sym_data  (i_sym_data),
    .o_sym_ready (o_sym_ready),
    .o_fir_en    (o_fir_en),
    .o_fir_valid (o_fir_valid),
    .o_fir_data  (o_fir_data),
    .o_phase     (o_phase),
    .o_busy      (o_busy),
    .o_underrun  (o_underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: present the next source symbol, step past the edge, note handshakes.
  task automatic tick();
    logic hs;
    i_sym_valid = (src_idx < src_n);
    i_sym_data  = (src_idx < src_n) ? src_q[src_idx] : 1'b0;
    hs = i_sym_valid & o_sym_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      src_idx++;
      hs_cnt++;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    src_n = 0; src_idx = 0;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    o_fir_en,    0);
    check({tag, "_valid"}, o_fir_valid, 0);
    check({tag, "_data"},  o_fir_data,  0);
    check({tag, "_phase"}, o_phase,     0);
    check({tag, "_ready"}, o_sym_ready, 0);
    check({tag, "_busy"},  o_busy,      0);
    check({tag, "_undr"},  o_underrun,  0);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_div = 8'd0;
    i_sym_valid = 1'b0; i_sym_data = 1'b0;

    // Streaming 1,0,1 with ratio 4
    do_reset();
    check_all_zero("rst");
    i_div = 8'd3;
    src_q[0] = 1'b1; src_q[1] = 1'b0; src_q[2] = 1'b1; src_n = 3; src_idx = 0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    check("run_busy", o_busy, 1);
    check("run_ready", o_sym_ready, 1);
    for (int c = 1; c <= 48; c++) begin
      tick();
      if (c % 4 == 0) begin
        check("s_en", o_fir_en, 1);
        check("s_phase", o_phase, (c / 4 - 1) % 4);
        check("s_valid", o_fir_valid, ((c / 4 - 1) % 4 == 0) ? 1 : 0);
      end else begin
        check("s_en_low", o_fir_en, 0);
      end
      if (c >= 4) check("s_data", o_fir_data, src_q[(c - 4) / 16]);
    end
    check("s_undr0", o_underrun, 0);
    ticks(4);
    check("s_ur_en", o_fir_en, 1);
    check("s_ur_valid", o_fir_valid, 0);
    check("s_ur_phase", o_phase, 0);
    check("s_ur_cnt", o_underrun, 1);

    // Ratio 1, upstream always valid
    do_reset();
    i_div = 8'd0;
    for (int k = 0; k < 64; k++) src_q[k] = k[0];
    src_n = 64; src_idx = 0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    ticks(2);
    u0 = o_underrun; h0 = hs_cnt;
    for (int c = 3; c <= 42; c++) begin
      tick();
      check("d0_en", o_fir_en, 1);
    end
    check("d0_undr", o_underrun, u0);
    check("d0_accepted", hs_cnt - h0, 10);

    // Three silent phase-0 slots, then upstream resumes
    do_reset();
    i_div = 8'd3;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      ticks(4);
      check("u_en", o_fir_en, 1);
      check("u_valid", o_fir_valid, 0);
      check("u_phase", o_phase, 0);
      check("u_cnt", o_underrun, k);
    end
    src_q[0] = 1'b1; src_n = 1; src_idx = 0;
    ticks(4);
    check("u_res_valid", o_fir_valid, 1);
    check("u_res_phase", o_phase, 0);
    check("u_res_data", o_fir_data, 1);
    check("u_res_cnt", o_underrun, 3);
    ticks(4);
    check("u_next_phase", o_phase, 1);

    // Stop at phase 1: phases 2 and 3 still issued, staged symbol dropped
    do_reset();
    i_div = 8'd3;
    src_q[0] = 1'b1; src_q[1] = 1'b0; src_n = 2; src_idx = 0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    ticks(8);
    check("st_p1_en", o_fir_en, 1);
    check("st_p1_phase", o_phase, 1);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    check("st_drain_busy", o_busy, 1);
    check("st_drain_ready", o_sym_ready, 0);
    ticks(3);
    check("st_p2_en", o_fir_en, 1);
    check("st_p2_phase", o_phase, 2);
    ticks(4);
    check("st_p3_en", o_fir_en, 1);
    check("st_p3_phase", o_phase, 3);
    check("st_p3_busy", o_busy, 1);
    tick();
    check("st_idle_busy", o_busy, 0);
    check("st_idle_ready", o_sym_ready, 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_fir_en) pulses++;
    end
    check("st_no_pulses", pulses, 0);
    check("st_data_held", o_fir_data, 1);
    i_start = 1'b1; tick(); i_start = 1'b0;
    ticks(4);
    check("st_re_en", o_fir_en, 1);
    check("st_re_valid", o_fir_valid, 0);
    check("st_re_undr", o_underrun, 1);

    // Reset in the middle of a symbol, then saturate and clear the underrun count
    do_reset();
    i_div = 8'd3;
    src_q[0] = 1'b1; src_q[1] = 1'b0; src_n = 2; src_idx = 0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    ticks(12);
    check("mr_en", o_fir_en, 1);
    check("mr_phase", o_phase, 2);
    i_rst = 1'b1; i_start = 1'b1; tick();
    check_all_zero("mr");
    i_rst = 1'b0; i_start = 1'b0;
    i_div = 8'd0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    check("mr_re_en", o_fir_en, 1);
    check("mr_re_phase", o_phase, 0);
    check("mr_re_valid", o_fir_valid, 0);
    ticks(300);
    check("mr_sat", o_underrun, 255);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    tick();
    check("mr_idle_busy", o_busy, 0);
    check("mr_idle_undr", o_underrun, 255);
    i_start = 1'b1; tick(); i_start = 1'b0;
    check("mr_clr_undr", o_underrun, 0);
    check("mr_clr_busy", o_busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
